// File: rtl/dp3_cell_sequencer.sv
// Raster-order walker for the 3D alignment DP cube; issues one cell at a time to the shared cell datapath.
// Optional macro DP3_BEST_TRACK_EN adds best-score/coordinate tracking for local alignment.
module dp3_cell_sequencer #(
    parameter int unsigned DIM_W   = 8,
    parameter int unsigned SCORE_W = 12,
    parameter int unsigned ADDR_W  = 24
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      abort,
    input  logic [DIM_W-1:0]          len_x,
    input  logic [DIM_W-1:0]          len_y,
    input  logic [DIM_W-1:0]          len_z,
    output logic                      busy,
    output logic                      done,
    output logic                      cell_valid,
    input  logic                      cell_ready,
    output logic [DIM_W-1:0]          cell_i,
    output logic [DIM_W-1:0]          cell_j,
    output logic [DIM_W-1:0]          cell_k,
    output logic [2:0]                cell_bnd,
    output logic [ADDR_W-1:0]         cell_addr,
    output logic                      cell_last,
    input  logic                      res_valid,
    input  logic signed [SCORE_W-1:0] res_score,
    output logic signed [SCORE_W-1:0] final_score
`ifdef DP3_BEST_TRACK_EN
    ,
    output logic signed [SCORE_W-1:0] best_score,
    output logic [DIM_W-1:0]          best_i,
    output logic [DIM_W-1:0]          best_j,
    output logic [DIM_W-1:0]          best_k
`endif
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FIN} state_t;

    state_t                      state_q, state_d;
    logic [DIM_W-1:0]            lx_q, ly_q, lz_q, lx_d, ly_d, lz_d;
    logic [DIM_W-1:0]            i_d, j_d, k_d;
    logic [ADDR_W-1:0]           addr_d;
    logic [2:0]                  bnd_d;
    logic                        last_d, upd;
    logic                        busy_d, done_d, valid_d;
    logic signed [SCORE_W-1:0]   fin_d;
`ifdef DP3_BEST_TRACK_EN
    logic signed [SCORE_W-1:0]   best_score_d;
    logic [DIM_W-1:0]            best_i_d, best_j_d, best_k_d;
`endif

    // Next-state, counter advance and output decode
    always_comb begin
        state_d = state_q;
        lx_d    = lx_q;
        ly_d    = ly_q;
        lz_d    = lz_q;
        i_d     = cell_i;
        j_d     = cell_j;
        k_d     = cell_k;
        addr_d  = cell_addr;
        bnd_d   = cell_bnd;
        last_d  = cell_last;
        fin_d   = final_score;
        upd     = 1'b0;
`ifdef DP3_BEST_TRACK_EN
        best_score_d = best_score;
        best_i_d     = best_i;
        best_j_d     = best_j;
        best_k_d     = best_k;
`endif
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    lx_d    = len_x;
                    ly_d    = len_y;
                    lz_d    = len_z;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    addr_d  = '0;
                    fin_d   = '0;
                    upd     = 1'b1;
                    state_d = ISSUE;
`ifdef DP3_BEST_TRACK_EN
                    best_score_d = {1'b1, {(SCORE_W-1){1'b0}}};
                    best_i_d     = '0;
                    best_j_d     = '0;
                    best_k_d     = '0;
`endif
                end
            end
            ISSUE: begin
                if (abort)           state_d = IDLE;
                else if (cell_ready) state_d = WAIT;
            end
            WAIT: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (res_valid) begin
`ifdef DP3_BEST_TRACK_EN
                    if (res_score > best_score) begin
                        best_score_d = res_score;
                        best_i_d     = cell_i;
                        best_j_d     = cell_j;
                        best_k_d     = cell_k;
                    end
`endif
                    if (cell_last) begin
                        fin_d   = res_score;
                        state_d = FIN;
                    end else begin
                        // k fastest, then j, then i
                        if (cell_k < lz_q) begin
                            k_d = cell_k + DIM_W'(1);
                        end else begin
                            k_d = '0;
                            if (cell_j < ly_q) begin
                                j_d = cell_j + DIM_W'(1);
                            end else begin
                                j_d = '0;
                                i_d = cell_i + DIM_W'(1);
                            end
                        end
                        addr_d  = cell_addr + ADDR_W'(1);
                        upd     = 1'b1;
                        state_d = ISSUE;
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (upd) begin
            bnd_d  = {i_d == '0, j_d == '0, k_d == '0};
            last_d = (i_d == lx_d) && (j_d == ly_d) && (k_d == lz_d);
        end

        busy_d  = (state_d != IDLE);
        done_d  = (state_d == FIN);
        valid_d = (state_d == ISSUE);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lx_q        <= '0;
            ly_q        <= '0;
            lz_q        <= '0;
            cell_i      <= '0;
            cell_j      <= '0;
            cell_k      <= '0;
            cell_addr   <= '0;
            cell_bnd    <= '0;
            cell_last   <= 1'b0;
            cell_valid  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            final_score <= '0;
`ifdef DP3_BEST_TRACK_EN
            best_score  <= '0;
            best_i      <= '0;
            best_j      <= '0;
            best_k      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            lx_q        <= lx_d;
            ly_q        <= ly_d;
            lz_q        <= lz_d;
            cell_i      <= i_d;
            cell_j      <= j_d;
            cell_k      <= k_d;
            cell_addr   <= addr_d;
            cell_bnd    <= bnd_d;
            cell_last   <= last_d;
            cell_valid  <= valid_d;
            busy        <= busy_d;
            done        <= done_d;
            final_score <= fin_d;
`ifdef DP3_BEST_TRACK_EN
            best_score  <= best_score_d;
            best_i      <= best_i_d;
            best_j      <= best_j_d;
            best_k      <= best_k_d;
`endif
        end
    end

endmodule
